// File: rtl/wfg_drive_pat_buf.sv
// rtl/wfg_drive_pat_buf.sv - FIFO-buffered pattern driver with sync-paced pops and windowed pin drive
module wfg_drive_pat_buf #(
    parameter int CHANNELS   = 8,
    parameter int AXIS_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wfg_core_sync_i,
    input  logic [7:0]                   wfg_core_subcycle_cnt_i,
    input  logic                         wfg_subcore_sync_i,
    input  logic [7:0]                   wfg_subcore_subcycle_cnt_i,
    input  logic                         cfg_core_sel_q_i,
    input  logic [CHANNELS-1:0]          ctrl_en_q_i,
    input  logic [2*CHANNELS-1:0]        patsel_q_i,
    input  logic [7:0]                   cfg_begin_q_i,
    input  logic [7:0]                   cfg_end_q_i,
    input  logic [CHANNELS-1:0]          cfg_idle_q_i,
    input  logic                         clr_underflow_i,
    output logic                         wfg_axis_tready_o,
    input  logic                         wfg_axis_tvalid_i,
    input  logic                         wfg_axis_tlast_i,
    input  logic [AXIS_WIDTH-1:0]        wfg_axis_tdata_i,
    output logic [CHANNELS-1:0]          pat_dout_o,
    output logic [CHANNELS-1:0]          pat_dout_en_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o,
    output logic                         underflow_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic                sync;
    logic [7:0]          cnt;
    logic [LW-1:0]       level, level_next;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic                tready_q;
    logic                push, pop, uflow;
    logic [CHANNELS-1:0] mem [DEPTH];
    logic [CHANNELS-1:0] pat;
    logic [CHANNELS-1:0] dout_next;
    logic                in_win;
    logic                unused_axis;

    // Only the low CHANNELS bits of a word ever reach a pin; tlast carries no meaning here.
    assign unused_axis = ^{wfg_axis_tlast_i, wfg_axis_tdata_i};

    assign sync = cfg_core_sel_q_i ? wfg_subcore_sync_i : wfg_core_sync_i;
    assign cnt  = cfg_core_sel_q_i ? wfg_subcore_subcycle_cnt_i : wfg_core_subcycle_cnt_i;

    assign push  = wfg_axis_tvalid_i && tready_q;
    assign pop   = sync && (level != '0);
    assign uflow = sync && (level == '0);

    assign wfg_axis_tready_o = tready_q;
    assign pat_dout_en_o     = ctrl_en_q_i;
    assign fifo_level_o      = level;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (!push && pop) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tready_q <= 1'b0;
        end else begin
            level    <= level_next;
            tready_q <= (level_next < LW'(DEPTH));
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Storage is not reset: the level counter alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wfg_axis_tdata_i[CHANNELS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat         <= '0;
            underflow_o <= 1'b0;
        end else begin
            if (pop) begin
                pat <= mem[rd_ptr];
            end
            if (uflow) begin
                underflow_o <= 1'b1;
            end else if (clr_underflow_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

    always_comb begin
        in_win = 1'b0;
        if (cfg_begin_q_i <= cfg_end_q_i) begin
            in_win = (cnt >= cfg_begin_q_i) && (cnt <= cfg_end_q_i);
        end else begin
            in_win = (cnt >= cfg_begin_q_i) || (cnt <= cfg_end_q_i);
        end
    end

    always_comb begin
        dout_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!ctrl_en_q_i[k]) begin
                dout_next[k] = 1'b0;
            end else if (!in_win) begin
                dout_next[k] = cfg_idle_q_i[k];
            end else begin
                case (patsel_q_i[2*k +: 2])
                    2'b00:   dout_next[k] = 1'b0;
                    2'b01:   dout_next[k] = 1'b1;
                    2'b10:   dout_next[k] = pat[k];
                    default: dout_next[k] = ~pat[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_dout_o <= '0;
        end else begin
            pat_dout_o <= dout_next;
        end
    end

endmodule

// File: tb/tb_wfg_drive_pat_buf.sv
// tb/tb_wfg_drive_pat_buf.sv - scoreboard bench for wfg_drive_pat_buf
module tb_wfg_drive_pat_buf;

    localparam int CHANNELS = 8;
    localparam int AXIS_WIDTH = 32;
    localparam int DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       core_sync, sub_sync, core_sel, clr_uf;
    logic [7:0]                 core_cnt, sub_cnt, cfg_begin, cfg_end;
    logic [CHANNELS-1:0]        ctrl_en, cfg_idle;
    logic [2*CHANNELS-1:0]      patsel;
    logic                       tready, tvalid, tlast;
    logic [AXIS_WIDTH-1:0]      tdata;
    logic [CHANNELS-1:0]        dout, dout_en;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       uf;

    wfg_drive_pat_buf #(.CHANNELS(CHANNELS), .AXIS_WIDTH(AXIS_WIDTH), .DEPTH(DEPTH)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .wfg_core_sync_i            (core_sync),
        .wfg_core_subcycle_cnt_i    (core_cnt),
        .wfg_subcore_sync_i         (sub_sync),
        .wfg_subcore_subcycle_cnt_i (sub_cnt),
        .cfg_core_sel_q_i           (core_sel),
        .ctrl_en_q_i                (ctrl_en),
        .patsel_q_i                 (patsel),
        .cfg_begin_q_i              (cfg_begin),
        .cfg_end_q_i                (cfg_end),
        .cfg_idle_q_i               (cfg_idle),
        .clr_underflow_i            (clr_uf),
        .wfg_axis_tready_o          (tready),
        .wfg_axis_tvalid_i          (tvalid),
        .wfg_axis_tlast_i           (tlast),
        .wfg_axis_tdata_i           (tdata),
        .pat_dout_o                 (dout),
        .pat_dout_en_o              (dout_en),
        .fifo_level_o               (level),
        .underflow_o                (uf)
    );

    always #5 clk = ~clk;

    typedef enum int {S_DOUT, S_LEVEL, S_TREADY, S_UF, S_DOUT_EN} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            S_DOUT:   return 32'(dout);
            S_LEVEL:  return 32'(level);
            S_TREADY: return 32'(tready);
            S_UF:     return 32'(uf);
            default:  return 32'(dout_en);
        endcase
    endfunction

    // Monitor: retire every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                compared++;
                if (sample(sb[i].sig) !== sb[i].val) begin
                    mismatched++;
                    $display("FAIL %s cyc=%0d actual=%h expected=%h",
                             sb[i].name, cyc, sample(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_v(input int d, input sig_e s, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc = cyc + d;
        e.sig = s;
        e.val = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] win_model(input logic [7:0] c, input logic [7:0] b,
                                             input logic [7:0] e, input logic [7:0] en,
                                             input logic [7:0] idle);
        logic w;
        if (b <= e) w = !(c < b || c > e);
        else        w = !(c > e && c < b);
        return w ? en : (idle & en);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; core_sync = 0; sub_sync = 0; core_sel = 0; clr_uf = 0;
        core_cnt = 0; sub_cnt = 0; cfg_begin = 0; cfg_end = 8'd255;
        ctrl_en = 8'hFF; cfg_idle = 8'h00; patsel = 16'hAAAA;
        tvalid = 0; tlast = 0; tdata = '0;

        // 1. reset state and tready rising one clock after release
        tick(); tick();
        compared++;
        if (tready !== 1'b0) begin
            mismatched++;
            $display("FAIL d_rst_tready cyc=%0d actual=%h expected=0", cyc, tready);
        end
        compared++;
        if (level !== '0) begin
            mismatched++;
            $display("FAIL d_rst_level cyc=%0d actual=%h expected=0", cyc, level);
        end
        compared++;
        if (uf !== 1'b0) begin
            mismatched++;
            $display("FAIL d_rst_uf cyc=%0d actual=%h expected=0", cyc, uf);
        end
        compared++;
        if (dout !== 8'h00) begin
            mismatched++;
            $display("FAIL d_rst_dout cyc=%0d actual=%h expected=00", cyc, dout);
        end
        expect_v(0, S_TREADY, 0, "rst_tready");
        expect_v(0, S_DOUT, 0, "rst_dout");
        expect_v(0, S_LEVEL, 0, "rst_level");
        expect_v(0, S_UF, 0, "rst_uf");
        tick();
        rst_n = 1;
        expect_v(0, S_TREADY, 0, "rel_tready0");
        expect_v(1, S_TREADY, 1, "rel_tready1");
        expect_v(1, S_LEVEL, 0, "rel_level");
        expect_v(1, S_DOUT, 0, "rel_dout");
        tick();
        compared++;
        if (tready !== 1'b1) begin
            mismatched++;
            $display("FAIL d_rel_tready cyc=%0d actual=%h expected=1", cyc, tready);
        end

        // 2. two words, two syncs, mode 10
        tvalid = 1; tdata = 32'hA5A5A5A5;
        expect_v(1, S_LEVEL, 1, "t2_lvl1");
        tick();
        tdata = 32'h5A5A5A5A;
        expect_v(1, S_LEVEL, 2, "t2_lvl2");
        tick();
        tvalid = 0; core_sync = 1;
        expect_v(1, S_LEVEL, 1, "t2_pop1_lvl");
        expect_v(1, S_DOUT, 0, "t2_latency");
        expect_v(2, S_DOUT, 8'hA5, "t2_pin_a5");
        tick();
        core_sync = 0;
        tick();
        core_sync = 1;
        expect_v(1, S_LEVEL, 0, "t2_pop2_lvl");
        expect_v(2, S_DOUT, 8'h5A, "t2_pin_5a");
        tick();
        core_sync = 0;
        tick();

        // 3. fill to DEPTH, fifth word held until a pop frees a slot
        for (int i = 0; i < 4; i++) begin
            tvalid = 1; tdata = 32'h11111111 * (i + 1);
            expect_v(1, S_LEVEL, i + 1, "t3_fill_lvl");
            expect_v(1, S_TREADY, (i < 3) ? 1 : 0, "t3_fill_tready");
            tick();
        end
        tdata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            expect_v(1, S_LEVEL, 4, "t3_full_lvl");
            expect_v(1, S_TREADY, 0, "t3_full_tready");
            tick();
        end
        core_sync = 1;
        expect_v(1, S_LEVEL, 3, "t3_pop_lvl");
        expect_v(1, S_TREADY, 1, "t3_pop_tready");
        expect_v(2, S_LEVEL, 4, "t3_refill_lvl");
        expect_v(2, S_TREADY, 0, "t3_refill_tready");
        expect_v(2, S_DOUT, 8'h11, "t3_pin_11");
        tick();
        core_sync = 0;
        tick();
        tvalid = 0;
        for (int j = 0; j < 4; j++) begin
            core_sync = 1;
            expect_v(1, S_LEVEL, 3 - j, "t3_drain_lvl");
            expect_v(2, S_DOUT, 8'h22 + 8'h11 * j, "t3_drain_pin");
            tick();
        end
        core_sync = 0;
        tick();

        // 4. underflow: set, hold pins, clear, set-wins, push on empty still underflows
        core_sync = 1;
        expect_v(1, S_UF, 1, "t4_uf_set");
        expect_v(1, S_LEVEL, 0, "t4_uf_lvl");
        expect_v(2, S_DOUT, 8'h55, "t4_pin_hold");
        tick();
        core_sync = 0; clr_uf = 1;
        expect_v(1, S_UF, 0, "t4_uf_clr");
        tick();
        core_sync = 1;
        expect_v(1, S_UF, 1, "t4_set_wins");
        tick();
        core_sync = 0;
        expect_v(1, S_UF, 0, "t4_uf_clr2");
        tick();
        clr_uf = 0; tvalid = 1; tdata = 32'h66; core_sync = 1;
        expect_v(1, S_UF, 1, "t4_no_bypass_uf");
        expect_v(1, S_LEVEL, 1, "t4_no_bypass_lvl");
        expect_v(2, S_DOUT, 8'h55, "t4_no_bypass_pin");
        tick();
        tvalid = 0; core_sync = 0; clr_uf = 1;
        expect_v(1, S_UF, 0, "t4_uf_clr3");
        tick();
        clr_uf = 0; core_sync = 1;
        expect_v(1, S_LEVEL, 0, "t4_pop_lvl");
        expect_v(1, S_UF, 0, "t4_pop_no_uf");
        expect_v(2, S_DOUT, 8'h66, "t4_pin_66");
        tick();
        core_sync = 0;
        tick();

        // 5. wrapping window sweep, mode 01, channel 7 disabled
        cfg_begin = 8'd250; cfg_end = 8'd5; cfg_idle = 8'h0F; ctrl_en = 8'h7F;
        patsel = 16'h5555;
        expect_v(0, S_DOUT_EN, 8'h7F, "t5_dout_en");
        for (int c = 0; c < 256; c++) begin
            core_cnt = 8'(c);
            expect_v(1, S_DOUT, win_model(8'(c), 8'd250, 8'd5, 8'h7F, 8'h0F), "t5_wrap_win");
            tick();
        end
        cfg_begin = 8'd10; cfg_end = 8'd20;
        for (int c = 0; c < 32; c++) begin
            core_cnt = 8'(c);
            expect_v(1, S_DOUT, win_model(8'(c), 8'd10, 8'd20, 8'h7F, 8'h0F), "t5_plain_win");
            tick();
        end

        // 6. subcore selection, simultaneous push and pop, then async reset mid-stream
        cfg_begin = 0; cfg_end = 8'd255; cfg_idle = 0; ctrl_en = 8'hFF; patsel = 16'hAAAA;
        core_sel = 1; sub_cnt = 8'd3; core_cnt = 8'd100;
        tvalid = 1; tdata = 32'h77;
        expect_v(1, S_LEVEL, 1, "t6_lvl1");
        tick();
        tdata = 32'h88;
        expect_v(1, S_LEVEL, 2, "t6_lvl2");
        tick();
        tvalid = 0; core_sync = 1;
        expect_v(1, S_LEVEL, 2, "t6_core_ignored");
        expect_v(1, S_UF, 0, "t6_core_no_uf");
        tick();
        core_sync = 0; sub_sync = 1;
        expect_v(1, S_LEVEL, 1, "t6_sub_pop");
        expect_v(2, S_DOUT, 8'h77, "t6_pin_77");
        tick();
        sub_sync = 0; tvalid = 1; tdata = 32'h99;
        expect_v(1, S_LEVEL, 2, "t6_lvl_back2");
        tick();
        tdata = 32'hAA; sub_sync = 1;
        expect_v(1, S_LEVEL, 2, "t6_push_pop_lvl");
        expect_v(1, S_TREADY, 1, "t6_push_pop_tready");
        expect_v(2, S_DOUT, 8'h88, "t6_pin_88");
        tick();
        tvalid = 0; sub_sync = 0;
        tick(); tick();
        rst_n = 0;
        expect_v(0, S_LEVEL, 0, "t6_arst_lvl");
        expect_v(0, S_TREADY, 0, "t6_arst_tready");
        expect_v(0, S_DOUT, 0, "t6_arst_dout");
        expect_v(0, S_UF, 0, "t6_arst_uf");
        tick();
        rst_n = 1;
        expect_v(2, S_LEVEL, 0, "t6_post_rst_lvl");
        tick(); tick(); tick(); tick();
        compared++;
        if (level !== '0) begin
            mismatched++;
            $display("FAIL d_end_level cyc=%0d actual=%h expected=0", cyc, level);
        end
        compared++;
        if (uf !== 1'b0) begin
            mismatched++;
            $display("FAIL d_end_uf cyc=%0d actual=%h expected=0", cyc, uf);
        end
        compared++;
        if (tready !== 1'b1) begin
            mismatched++;
            $display("FAIL d_end_tready cyc=%0d actual=%h expected=1", cyc, tready);
        end
        compared++;
        if (dout !== 8'h00) begin
            mismatched++;
            $display("FAIL d_end_dout cyc=%0d actual=%h expected=00", cyc, dout);
        end

        foreach (sb[i]) begin
            mismatched++;
            $display("FAIL %s actual=unchecked expected=%h", sb[i].name, sb[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
